v_dsampler_ctrl: RTL and testbench
==================================

# v_dsampler_ctrl

Frame-synchronous controller for the 8-pixel-per-clock video down-sampler datapath. It snoops the datapath's input AXI4-Stream handshake and drives the datapath's per-beat phase and mode controls. It holds run-time mode changes (column/line decimation, bypass) until a frame boundary, and gates the datapath until the first start-of-frame. It also checks the frame geometry against programmed width/height and reports frame, line and error status.

## Interface
Parameters:
- CNT_W, 16, width of beat, line and frame counters and of cfg_width/cfg_height.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- cfg_enable  in  1  level; 0 forces IDLE at the next frame boundary.
- cfg_col_down  in  1  requested column decimation.
- cfg_line_down  in  1  requested line decimation.
- cfg_update  in  1  one-cycle pulse; loads cfg_col_down/cfg_line_down into the shadow register.
- cfg_width  in  CNT_W  expected beats per line; must be ≥1.
- cfg_height  in  CNT_W  expected lines per frame; must be ≥1.
- s_axis_tvalid  in  1  snooped input valid.
- s_axis_tready  in  1  snooped input ready.
- s_axis_tlast  in  1  snooped end-of-line.
- s_axis_tuser  in  1  snooped start-of-frame.
- dp_col_down  out  1  applied column mode; reset 0.
- dp_line_down  out  1  applied line mode; reset 0.
- dp_drop  out  1  datapath must discard the current beat; reset 1.
- dp_beat_phase  out  1  parity of the current beat within the line; reset 0.
- dp_line_phase  out  1  parity of the current line within the frame; reset 0.
- line_cnt  out  CNT_W  lines completed in the current frame; reset 0.
- frame_cnt  out  CNT_W  frames completed, wrapping; reset 0.
- busy  out  1  high in ACTIVE; reset 0.
- err_sof_early, err_eol_early, err_eol_late  out  1 each  sticky error flags; reset 0.
- err_clr  in  1  pulse; clears all err_* flags.

## Operation
- Beat accept: acc = s_axis_tvalid & s_axis_tready. Only accepted beats advance any state.
- Shadow register: loaded on cfg_update. Reset value 0/0.
- FSM states: IDLE, WAIT_SOF, ACTIVE. Reset state is IDLE.
- IDLE: dp_drop=1. Go to WAIT_SOF when cfg_enable=1.
- WAIT_SOF:
  - dp_drop = ~s_axis_tuser, combinational, so the SOF beat itself passes.
  - dp_col_down/dp_line_down copied from the shadow register every cycle.
  - cfg_enable=0 → IDLE.
  - acc & tuser → ACTIVE.
  - Other accepted beats are dropped with no counter change.
- ACTIVE:
  - dp_drop=0. dp_col_down/dp_line_down frozen.
  - beat_cnt increments on each acc. On acc & tlast: beat_cnt clears, line_cnt increments, dp_line_phase toggles.
  - dp_beat_phase equals beat_cnt[0].
  - When acc & tlast makes line_cnt equal cfg_height: frame_cnt increments (wraps at 2^CNT_W), line_cnt clears, dp_line_phase clears. Go to WAIT_SOF, or to IDLE if cfg_enable=0.
- SOF beat (accepted in WAIT_SOF, or a restart in ACTIVE): it is beat 0 of line 0. After it, beat_cnt=1 and dp_beat_phase=1, unless tlast is also set (then line end applies).
- Early SOF: acc & tuser in ACTIVE with beat_cnt≠0 or line_cnt≠0. Set err_sof_early and restart the frame at this beat; frame_cnt does not increment.
- Geometry checks, applied at acc & tlast:
  - beat_cnt+1 < cfg_width → set err_eol_early.
  - Accepted beat with beat_cnt+1 > cfg_width and no tlast → set err_eol_late. This sets once per line; counting continues until tlast.
- Simultaneous events: err_clr and a new error in the same cycle leaves the flag set. cfg_update while copying leaves the new value visible the next cycle.

## Timing
- Counters, phases, dp_col/line_down, err_* and busy are registered. They update on the edge that accepts the beat and are valid for the next beat.
- dp_drop is combinational from the state and s_axis_tuser; zero latency.
- Mode-change latency is from cfg_update to the first SOF accepted at least one cycle later.
- Reset asserted mid-frame: all outputs return to their reset values asynchronously. After release, the block waits for a fresh SOF.
- The block never drives tready; stalls (tvalid & ~tready) hold all state.

## Configuration
- DSCTRL_ERR_EN defined: cfg_width comparison and all three err_* flags are implemented as described.
- DSCTRL_ERR_EN undefined:
  - err_* are tied to 0, err_clr and cfg_width are ignored, and the beat-count comparators are removed.
  - Early SOF still restarts the frame, silently.
  - Frame end still uses cfg_height.

## Test plan
- Reset → enable, cfg_width=4, cfg_height=2, three 4-beat lines with SOF on beat 0 → phases 0,1,0,1 per line, dp_line_phase 0,1. frame_cnt=1 after the second tlast. Third line arrives in WAIT_SOF with dp_drop=1.
- Two non-SOF beats, then SOF → first two dropped (dp_drop=1), SOF beat passes with dp_drop=0, busy=1 next cycle.
- cfg_update col=1,line=1 mid-frame → dp_col_down stays 0 until the frame ends, reads 1 in WAIT_SOF before the next SOF.
- Line of 3 beats with cfg_width=4 → err_eol_early=1. Line of 6 beats → err_eol_late=1 once. err_clr → both 0.
- SOF at beat 2 of line 1 → err_sof_early=1, line_cnt=0, beat_cnt=1, frame_cnt unchanged.
- aresetn low for 1 cycle mid-line with tvalid held high → outputs return to reset values immediately. Post-reset beats are dropped until the next SOF.

Source files
------------

// File: rtl/v_dsampler_ctrl_if.sv
// Snooped AXI4-Stream handshake between the video source and the down-sampler datapath.
// Only the controller-relevant sideband is carried: valid/ready, end-of-line (tlast) and start-of-frame (tuser).
interface v_dsampler_ctrl_if;
  logic tvalid;
  logic tready;
  logic tlast;
  logic tuser;

  modport master (output tvalid, output tready, output tlast, output tuser);
  modport slave  (input  tvalid, input  tready, input  tlast, input  tuser);
endinterface

// File: rtl/v_dsampler_ctrl.sv
// Frame-synchronous controller for the 8-pixel/clock video down-sampler: mode shadowing, SOF gating, geometry checks.
// Optional DSCTRL_ERR_EN: builds the cfg_width checks and the sticky err_* flags; without it they are tied off.
module v_dsampler_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  v_dsampler_ctrl_if.slave s_axis,
  input  logic             cfg_enable,
  input  logic             cfg_col_down,
  input  logic             cfg_line_down,
  input  logic             cfg_update,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_height,
  input  logic             err_clr,
  output logic             dp_col_down,
  output logic             dp_line_down,
  output logic             dp_drop,
  output logic             dp_beat_phase,
  output logic             dp_line_phase,
  output logic [CNT_W-1:0] line_cnt,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy,
  output logic             err_sof_early,
  output logic             err_eol_early,
  output logic             err_eol_late
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_ACTIVE} state_t;

  state_t           state_q, state_d;
  logic             shadow_col_q, shadow_col_d, shadow_line_q, shadow_line_d;
  logic             dp_col_q, dp_col_d, dp_line_q, dp_line_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d, line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             line_phase_q, line_phase_d;

  logic             acc, sof, beat_en;
  logic [CNT_W-1:0] beat_idx, line_idx, line_next;
  logic             lphase_idx;

  always_comb begin
    acc     = s_axis.tvalid & s_axis.tready;
    // A SOF beat counts whether it opens the frame from WAIT_SOF or restarts one in ACTIVE.
    beat_en = acc & ((state_q == S_ACTIVE) |
                     ((state_q == S_WAIT_SOF) & cfg_enable & s_axis.tuser));
    sof        = beat_en & s_axis.tuser;
    beat_idx   = sof ? '0 : beat_cnt_q;
    line_idx   = sof ? '0 : line_cnt_q;
    lphase_idx = sof ? 1'b0 : line_phase_q;
    line_next  = line_idx + CNT_W'(1);

    state_d       = state_q;
    shadow_col_d  = shadow_col_q;
    shadow_line_d = shadow_line_q;
    dp_col_d      = dp_col_q;
    dp_line_d     = dp_line_q;
    beat_cnt_d    = beat_cnt_q;
    line_cnt_d    = line_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    line_phase_d  = line_phase_q;
    dp_drop       = 1'b1;

    if (cfg_update) begin
      shadow_col_d  = cfg_col_down;
      shadow_line_d = cfg_line_down;
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_enable) state_d = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        dp_drop = ~s_axis.tuser;
        if (!cfg_enable)                state_d = S_IDLE;
        else if (acc && s_axis.tuser)   state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        dp_drop = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (beat_en) begin
      if (s_axis.tlast) begin
        beat_cnt_d = '0;
        if (line_next == cfg_height) begin
          line_cnt_d   = '0;
          line_phase_d = 1'b0;
          frame_cnt_d  = frame_cnt_q + CNT_W'(1);
          state_d      = cfg_enable ? S_WAIT_SOF : S_IDLE;
        end else begin
          line_cnt_d   = line_next;
          line_phase_d = ~lphase_idx;
          state_d      = S_ACTIVE;
        end
      end else begin
        beat_cnt_d   = beat_idx + CNT_W'(1);
        line_cnt_d   = line_idx;
        line_phase_d = lphase_idx;
        state_d      = S_ACTIVE;
      end
    end

    // Modes track the shadow (including a same-cycle update) whenever the next state waits for SOF.
    if (state_d == S_WAIT_SOF) begin
      dp_col_d  = shadow_col_d;
      dp_line_d = shadow_line_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      shadow_col_q  <= 1'b0;
      shadow_line_q <= 1'b0;
      dp_col_q      <= 1'b0;
      dp_line_q     <= 1'b0;
      beat_cnt_q    <= '0;
      line_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      line_phase_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_col_q  <= shadow_col_d;
      shadow_line_q <= shadow_line_d;
      dp_col_q      <= dp_col_d;
      dp_line_q     <= dp_line_d;
      beat_cnt_q    <= beat_cnt_d;
      line_cnt_q    <= line_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      line_phase_q  <= line_phase_d;
    end
  end

`ifdef DSCTRL_ERR_EN
  logic             err_sof_q, err_sof_d, err_early_q, err_early_d, err_late_q, err_late_d;
  logic             late_seen_q, late_seen_d, late_seen_idx;
  logic [CNT_W:0]   beat_num;

  always_comb begin
    beat_num      = {1'b0, beat_idx} + (CNT_W+1)'(1);
    late_seen_idx = sof ? 1'b0 : late_seen_q;
    late_seen_d   = late_seen_q;
    err_sof_d     = err_sof_q   & ~err_clr;
    err_early_d   = err_early_q & ~err_clr;
    err_late_d    = err_late_q  & ~err_clr;

    if (acc && s_axis.tuser && state_q == S_ACTIVE &&
        (beat_cnt_q != '0 || line_cnt_q != '0))
      err_sof_d = 1'b1;

    if (beat_en) begin
      if (s_axis.tlast) begin
        late_seen_d = 1'b0;
        if (beat_num < {1'b0, cfg_width}) err_early_d = 1'b1;
      end else begin
        late_seen_d = late_seen_idx;
        if (beat_num > {1'b0, cfg_width} && !late_seen_idx) begin
          err_late_d  = 1'b1;
          late_seen_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_sof_q   <= 1'b0;
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
      late_seen_q <= 1'b0;
    end else begin
      err_sof_q   <= err_sof_d;
      err_early_q <= err_early_d;
      err_late_q  <= err_late_d;
      late_seen_q <= late_seen_d;
    end
  end

  assign err_sof_early = err_sof_q;
  assign err_eol_early = err_early_q;
  assign err_eol_late  = err_late_q;
`else
  logic unused_err_cfg;
  assign unused_err_cfg = ^{cfg_width, err_clr};
  assign err_sof_early  = 1'b0;
  assign err_eol_early  = 1'b0;
  assign err_eol_late   = 1'b0;
`endif

  assign dp_col_down   = dp_col_q;
  assign dp_line_down  = dp_line_q;
  assign dp_beat_phase = beat_cnt_q[0];
  assign dp_line_phase = line_phase_q;
  assign line_cnt      = line_cnt_q;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_v_dsampler_ctrl.sv
// Directed self-checking bench for v_dsampler_ctrl; error-flag expectations follow DSCTRL_ERR_EN.
module tb_v_dsampler_ctrl;
`ifdef DSCTRL_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  localparam int CNT_W = 16;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic             cfg_enable, cfg_col_down, cfg_line_down, cfg_update, err_clr;
  logic [CNT_W-1:0] cfg_width, cfg_height;
  logic             dp_col_down, dp_line_down, dp_drop, dp_beat_phase, dp_line_phase;
  logic [CNT_W-1:0] line_cnt, frame_cnt;
  logic             busy, err_sof_early, err_eol_early, err_eol_late;

  int   checks   = 0;
  int   failures = 0;
  logic drop_obs, bp_obs, lp_obs;

  v_dsampler_ctrl_if s_if ();

  v_dsampler_ctrl #(.CNT_W(CNT_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s_if.slave),
    .cfg_enable(cfg_enable), .cfg_col_down(cfg_col_down), .cfg_line_down(cfg_line_down),
    .cfg_update(cfg_update), .cfg_width(cfg_width), .cfg_height(cfg_height), .err_clr(err_clr),
    .dp_col_down(dp_col_down), .dp_line_down(dp_line_down), .dp_drop(dp_drop),
    .dp_beat_phase(dp_beat_phase), .dp_line_phase(dp_line_phase),
    .line_cnt(line_cnt), .frame_cnt(frame_cnt), .busy(busy),
    .err_sof_early(err_sof_early), .err_eol_early(err_eol_early), .err_eol_late(err_eol_late)
  );

  always #5 aclk = ~aclk;

  // One bus cycle: apply inputs, sample combinational drop and current phases, then step past the edge.
  task automatic drive(input logic v, input logic l, input logic u);
    s_if.tvalid = v; s_if.tready = 1'b1; s_if.tlast = l; s_if.tuser = u;
    #1;
    drop_obs = dp_drop; bp_obs = dp_beat_phase; lp_obs = dp_line_phase;
    @(posedge aclk); #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; cfg_enable = 1'b0; cfg_col_down = 1'b0; cfg_line_down = 1'b0;
    cfg_update = 1'b0; err_clr = 1'b0; cfg_width = 16'd4; cfg_height = 16'd2;
    s_if.tvalid = 1'b0; s_if.tready = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++; if (dp_drop !== 1'b1) begin failures++; $display("FAIL reset_drop got=%0b exp=1", dp_drop); end
    checks++; if ({dp_col_down, dp_line_down, dp_beat_phase, dp_line_phase, busy} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {dp_col_down, dp_line_down, dp_beat_phase, dp_line_phase, busy}); end
    checks++; if ({line_cnt, frame_cnt} !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", line_cnt, frame_cnt); end
    checks++; if ({err_sof_early, err_eol_early, err_eol_late} !== 3'b0) begin
      failures++; $display("FAIL reset_err got=%b exp=000", {err_sof_early, err_eol_early, err_eol_late}); end
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_frame();
    cfg_enable = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL frame_wait_busy got=%0b exp=0", busy); end
    for (int ln = 0; ln < 2; ln++) begin
      for (int b = 0; b < 4; b++) begin
        drive(1'b1, b == 3, (ln == 0) && (b == 0));
        checks++; if (drop_obs !== 1'b0) begin failures++; $display("FAIL frame_drop l%0d b%0d got=%0b exp=0", ln, b, drop_obs); end
        checks++; if (bp_obs !== b[0]) begin failures++; $display("FAIL frame_beat_phase l%0d b%0d got=%0b exp=%0b", ln, b, bp_obs, b[0]); end
        checks++; if (lp_obs !== ln[0]) begin failures++; $display("FAIL frame_line_phase l%0d b%0d got=%0b exp=%0b", ln, b, lp_obs, ln[0]); end
        if (ln == 0 && b == 3) begin
          checks++; if (line_cnt !== 16'd1) begin failures++; $display("FAIL frame_line_cnt got=%0d exp=1", line_cnt); end
        end
      end
    end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL frame_cnt got=%0d exp=1", frame_cnt); end
    checks++; if (line_cnt !== 16'd0) begin failures++; $display("FAIL frame_line_clr got=%0d exp=0", line_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL frame_end_busy got=%0b exp=0", busy); end
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, b == 3, 1'b0);
      checks++; if (drop_obs !== 1'b1) begin failures++; $display("FAIL third_line_drop b%0d got=%0b exp=1", b, drop_obs); end
    end
    checks++; if ({frame_cnt, line_cnt} !== {16'd1, 16'd0}) begin
      failures++; $display("FAIL third_line_cnt got=%0d/%0d exp=1/0", frame_cnt, line_cnt); end
  endtask

  task automatic test_sof_wait();
    for (int b = 0; b < 2; b++) begin
      drive(1'b1, 1'b0, 1'b0);
      checks++; if (drop_obs !== 1'b1) begin failures++; $display("FAIL presof_drop b%0d got=%0b exp=1", b, drop_obs); end
    end
    drive(1'b1, 1'b0, 1'b1);
    checks++; if (drop_obs !== 1'b0) begin failures++; $display("FAIL sof_drop got=%0b exp=0", drop_obs); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sof_busy got=%0b exp=1", busy); end
    checks++; if (dp_beat_phase !== 1'b1) begin failures++; $display("FAIL sof_beat_phase got=%0b exp=1", dp_beat_phase); end
  endtask

  task automatic test_mode_update();
    cfg_col_down = 1'b1; cfg_line_down = 1'b1; cfg_update = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    cfg_update = 1'b0;
    checks++; if ({dp_col_down, dp_line_down} !== 2'b00) begin failures++; $display("FAIL mode_hold got=%b exp=00", {dp_col_down, dp_line_down}); end
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    checks++; if (line_cnt !== 16'd1) begin failures++; $display("FAIL mode_line_cnt got=%0d exp=1", line_cnt); end
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, b == 3, 1'b0);
      if (b == 2) begin
        checks++; if (dp_col_down !== 1'b0) begin failures++; $display("FAIL mode_frozen got=%0b exp=0", dp_col_down); end
      end
    end
    checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL mode_frame_cnt got=%0d exp=2", frame_cnt); end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if ({dp_col_down, dp_line_down} !== 2'b11) begin failures++; $display("FAIL mode_applied got=%b exp=11", {dp_col_down, dp_line_down}); end
  endtask

  task automatic test_geometry();
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    checks++; if (err_eol_early !== ERR_EN) begin failures++; $display("FAIL eol_early got=%0b exp=%0b", err_eol_early, ERR_EN); end
    checks++; if (err_eol_late !== 1'b0) begin failures++; $display("FAIL eol_late_short got=%0b exp=0", err_eol_late); end
    for (int b = 0; b < 6; b++) begin
      drive(1'b1, b == 5, 1'b0);
      if (b == 3) begin
        checks++; if (err_eol_late !== 1'b0) begin failures++; $display("FAIL eol_late_at_width got=%0b exp=0", err_eol_late); end
      end
      if (b == 4) begin
        checks++; if (err_eol_late !== ERR_EN) begin failures++; $display("FAIL eol_late got=%0b exp=%0b", err_eol_late, ERR_EN); end
      end
    end
    checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL geom_frame_cnt got=%0d exp=3", frame_cnt); end
    err_clr = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
    checks++; if ({err_eol_early, err_eol_late} !== 2'b00) begin failures++; $display("FAIL err_clr got=%b exp=00", {err_eol_early, err_eol_late}); end
  endtask

  task automatic test_sof_early();
    for (int b = 0; b < 4; b++) drive(1'b1, b == 3, b == 0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    checks++; if (err_sof_early !== ERR_EN) begin failures++; $display("FAIL sof_early got=%0b exp=%0b", err_sof_early, ERR_EN); end
    checks++; if (line_cnt !== 16'd0) begin failures++; $display("FAIL sof_early_line got=%0d exp=0", line_cnt); end
    checks++; if ({dp_beat_phase, dp_line_phase, busy} !== 3'b101) begin
      failures++; $display("FAIL sof_early_phase got=%b exp=101", {dp_beat_phase, dp_line_phase, busy}); end
    checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL sof_early_frame got=%0d exp=3", frame_cnt); end
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    checks++; if (line_cnt !== 16'd1) begin failures++; $display("FAIL restart_line got=%0d exp=1", line_cnt); end
    checks++; if (err_eol_early !== 1'b0) begin failures++; $display("FAIL restart_eol got=%0b exp=0", err_eol_early); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0);
    checks++; if ({busy, dp_beat_phase} !== 2'b11) begin failures++; $display("FAIL pre_rst got=%b exp=11", {busy, dp_beat_phase}); end
    #3 aresetn = 1'b0;
    #1;
    checks++; if ({dp_drop, busy, dp_col_down, dp_line_down, dp_beat_phase, dp_line_phase} !== 6'b100000) begin
      failures++; $display("FAIL mid_rst_ctrl got=%b exp=100000", {dp_drop, busy, dp_col_down, dp_line_down, dp_beat_phase, dp_line_phase}); end
    checks++; if ({line_cnt, frame_cnt} !== 32'd0) begin failures++; $display("FAIL mid_rst_cnt got=%0d/%0d exp=0/0", line_cnt, frame_cnt); end
    checks++; if (err_sof_early !== 1'b0) begin failures++; $display("FAIL mid_rst_err got=%0b exp=0", err_sof_early); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    for (int b = 0; b < 2; b++) begin
      drive(1'b1, 1'b0, 1'b0);
      checks++; if (drop_obs !== 1'b1) begin failures++; $display("FAIL post_rst_drop b%0d got=%0b exp=1", b, drop_obs); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_rst_busy got=%0b exp=0", busy); end
    drive(1'b1, 1'b0, 1'b1);
    checks++; if (drop_obs !== 1'b0) begin failures++; $display("FAIL post_rst_sof got=%0b exp=0", drop_obs); end
    checks++; if ({busy, frame_cnt} !== {1'b1, 16'd0}) begin failures++; $display("FAIL post_rst_active got=%0b/%0d exp=1/0", busy, frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_sof_wait();
    test_mode_update();
    test_geometry();
    test_sof_early();
    test_reset_mid();
    drive(1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
